// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the per-state datapath strobes, with optional early branch retirement and a memory-wait watchdog.
package mcu_types_pkg;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_t;
endpackage

module multicycle_control_unit
    import mcu_types_pkg::*;
#(
    parameter bit          FAST_BRANCH = 1'b1,
    parameter int unsigned STALL_LIMIT = 0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] instruction,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        zero,
    output logic        iREN,
    output logic        dREN,
    output logic        dWEN,
    output logic        IRWEN,
    output logic        PCWEN,
    output logic        RegWEN,
    output logic        MemtoReg,
    output logic [1:0]  ALUsrc,
    output logic [1:0]  Regdst,
    output logic [2:0]  jsel,
    output aluop_t      aluop,
    output logic        halt,
    output logic        mem_err,
    output logic [2:0]  state
);
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J     = 6'b000010, OP_JAL   = 6'b000011,
                           OP_BEQ   = 6'b000100, OP_BNE   = 6'b000101, OP_ADDI  = 6'b001000,
                           OP_ADDIU = 6'b001001, OP_SLTI  = 6'b001010, OP_SLTIU = 6'b001011,
                           OP_ANDI  = 6'b001100, OP_ORI   = 6'b001101, OP_XORI  = 6'b001110,
                           OP_LUI   = 6'b001111, OP_LW    = 6'b100011, OP_SW    = 6'b101011,
                           OP_HALT  = 6'b111111;
    localparam logic [5:0] FN_SLL  = 6'b000000, FN_SRL  = 6'b000010, FN_JR   = 6'b001000,
                           FN_ADD  = 6'b100000, FN_ADDU = 6'b100001, FN_SUB  = 6'b100010,
                           FN_SUBU = 6'b100011, FN_AND  = 6'b100100, FN_OR   = 6'b100101,
                           FN_XOR  = 6'b100110, FN_NOR  = 6'b100111, FN_SLT  = 6'b101010,
                           FN_SLTU = 6'b101011;

    // A zero limit still needs a 1-bit counter so the logic stays well-formed.
    localparam int          CW    = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

    typedef enum logic [3:0] {
        CL_NOP, CL_RALU, CL_IALU, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR, CL_HALT
    } iclass_t;

    logic [5:0]    opcode, funct;
    logic [4:0]    rt, rd;
    logic          unused_fields;
    iclass_t       iclass;
    aluop_t        dec_alu;
    logic [1:0]    dec_src;
    state_t        cur, nxt;
    logic [CW-1:0] wait_cnt;
    logic          waiting, timeout, err_q;

    assign opcode        = instruction[31:26];
    assign rt            = instruction[20:16];
    assign rd            = instruction[15:11];
    assign funct         = instruction[5:0];
    assign unused_fields = ^{instruction[25:21], instruction[10:6]};

    always_comb begin
        iclass  = CL_NOP;
        dec_alu = ALU_ADD;
        dec_src = 2'd0;
        case (opcode)
            OP_RTYPE: begin
                iclass = CL_RALU;
                case (funct)
                    FN_SLL:           dec_alu = ALU_SLL;
                    FN_SRL:           dec_alu = ALU_SRL;
                    FN_ADD, FN_ADDU:  dec_alu = ALU_ADD;
                    FN_SUB, FN_SUBU:  dec_alu = ALU_SUB;
                    FN_AND:           dec_alu = ALU_AND;
                    FN_OR:            dec_alu = ALU_OR;
                    FN_XOR:           dec_alu = ALU_XOR;
                    FN_NOR:           dec_alu = ALU_NOR;
                    FN_SLT:           dec_alu = ALU_SLT;
                    FN_SLTU:          dec_alu = ALU_SLTU;
                    FN_JR:            iclass  = CL_JR;
                    default:          iclass  = CL_NOP;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin iclass = CL_IALU; dec_alu = ALU_ADD;  dec_src = 2'd1; end
            OP_SLTI:           begin iclass = CL_IALU; dec_alu = ALU_SLT;  dec_src = 2'd1; end
            OP_SLTIU:          begin iclass = CL_IALU; dec_alu = ALU_SLTU; dec_src = 2'd1; end
            OP_ANDI:           begin iclass = CL_IALU; dec_alu = ALU_AND;  dec_src = 2'd2; end
            OP_ORI:            begin iclass = CL_IALU; dec_alu = ALU_OR;   dec_src = 2'd2; end
            OP_XORI:           begin iclass = CL_IALU; dec_alu = ALU_XOR;  dec_src = 2'd2; end
            OP_LUI:            begin iclass = CL_IALU; dec_alu = ALU_OR;   dec_src = 2'd3; end
            OP_LW:             begin iclass = CL_LW;   dec_alu = ALU_ADD;  dec_src = 2'd1; end
            OP_SW:             begin iclass = CL_SW;   dec_alu = ALU_ADD;  dec_src = 2'd1; end
            OP_BEQ:            begin iclass = CL_BEQ;  dec_alu = ALU_SUB;  end
            OP_BNE:            begin iclass = CL_BNE;  dec_alu = ALU_SUB;  end
            OP_J:              iclass = CL_J;
            OP_JAL:            iclass = CL_JAL;
            OP_HALT:           iclass = CL_HALT;
            default:           iclass = CL_NOP;
        endcase
    end

    // Only the hit belonging to the current state counts as progress.
    assign waiting = ((cur == ST_FETCH) && !ihit) || ((cur == ST_MEM) && !dhit);
    assign timeout = (STALL_LIMIT != 0) && waiting && (wait_cnt == LIMIT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cur      <= ST_FETCH;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            cur <= nxt;
            if (timeout)
                err_q <= 1'b1;
            if ((STALL_LIMIT == 0) || (nxt != cur) || !waiting)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        nxt      = cur;
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        IRWEN    = 1'b0;
        PCWEN    = 1'b0;
        RegWEN   = 1'b0;
        MemtoReg = 1'b0;
        ALUsrc   = 2'd0;
        Regdst   = 2'd0;
        jsel     = 3'd0;
        aluop    = ALU_SLL;
        halt     = 1'b0;
        case (cur)
            ST_FETCH: begin
                iREN = 1'b1;
                if (ihit) begin
                    IRWEN = 1'b1;
                    PCWEN = 1'b1;
                    nxt   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (iclass)
                    CL_HALT: nxt = ST_HALTED;
                    CL_J: begin
                        PCWEN = 1'b1;
                        jsel  = 3'd2;
                        nxt   = ST_FETCH;
                    end
                    CL_JAL: begin
                        PCWEN  = 1'b1;
                        jsel   = 3'd2;
                        RegWEN = 1'b1;
                        Regdst = 2'd2;
                        nxt    = ST_FETCH;
                    end
                    default: nxt = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                aluop  = dec_alu;
                ALUsrc = dec_src;
                case (iclass)
                    CL_BEQ, CL_BNE: begin
                        PCWEN = (iclass == CL_BEQ) ? zero : !zero;
                        jsel  = 3'd1;
                        nxt   = FAST_BRANCH ? ST_FETCH : ST_WB;
                    end
                    CL_JR: begin
                        PCWEN = 1'b1;
                        jsel  = 3'd3;
                        nxt   = ST_FETCH;
                    end
                    CL_LW, CL_SW:     nxt = ST_MEM;
                    CL_RALU, CL_IALU: nxt = ST_WB;
                    default:          nxt = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                dREN = (iclass == CL_LW);
                dWEN = (iclass == CL_SW);
                if (dhit)
                    nxt = (iclass == CL_LW) ? ST_WB : ST_FETCH;
            end
            ST_WB: begin
                nxt = ST_FETCH;
                case (iclass)
                    CL_RALU: RegWEN = (rd != 5'd0);
                    CL_IALU: begin
                        RegWEN = (rt != 5'd0);
                        Regdst = 2'd1;
                    end
                    CL_LW: begin
                        RegWEN   = (rt != 5'd0);
                        Regdst   = 2'd1;
                        MemtoReg = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_HALTED: halt = 1'b1;
            default:   nxt = ST_FETCH;
        endcase
        if (timeout)
            nxt = ST_HALTED;
    end

    assign state   = cur;
    assign mem_err = err_q;
endmodule
